// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
// State encoding and counter sizing live here so top and bench agree on them.
package adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } adder_state_t;

   // Width of the digit counter; a single-digit adder still needs one bit.
   function automatic int cnt_width(input int width, input int digit);
      int n;
      int w;
      n = width / digit;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a client and the serial adder.
// start is a request taken at a rising edge where busy=0; done is a one-cycle valid for s/cout/ovf.
interface serial_adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   adder_state_t     state;

   modport master (
      output start, a, b, cin,
      input  busy, done, s, cout, ovf, state
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, s, cout, ovf, state
   );

endinterface

// File: rtl/full_adder_cell.sv
// Single-bit full adder, the arithmetic primitive of the serial adder chain.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// WIDTH-bit adder that sums DIGIT bits per clock through a registered carry.
// Results are loaded only on the final digit and held until the next completion.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_adder: WIDTH (%0d) must be >= 2 and a multiple of DIGIT (%0d)",
                WIDTH, DIGIT);
      end
   endgenerate

   adder_state_t     state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             ovf_q;

   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] sum_d;
   logic [WIDTH-1:0] acc_next;

   assign c[0] = carry;

   genvar i;
   generate
      for (i = 0; i < DIGIT; i++) begin : g_chain
         full_adder_cell u_fa (
            .a   (a_sh[i]),
            .b   (b_sh[i]),
            .cin (c[i]),
            .s   (sum_d[i]),
            .cout(c[i+1])
         );
      end
   endgenerate

   // New digits enter from the MSB side so the LSB digit ends up at bit 0.
   always_comb begin
      acc_next = acc >> DIGIT;
      acc_next[WIDTH-1 -: DIGIT] = sum_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  carry  <= bus.cin;
                  acc    <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               acc   <= acc_next;
               carry <= c[DIGIT];
               cnt   <= cnt + CW'(1);
               // On the last digit the top cell of the chain is the operand MSB.
               if (cnt == LAST) begin
                  s_q    <= acc_next;
                  cout_q <= c[DIGIT];
                  ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.s     = s_q;
   assign bus.cout  = cout_q;
   assign bus.ovf   = ovf_q;
   assign bus.state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-digit and a 16-bit/4-digit instance,
// driver tasks pushing expected results, monitors popping on done.
module tb_serial_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16.slave)
  );

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  logic [17:0] exp8_q[$];
  logic [17:0] exp16_q[$];
  logic [17:0] e8;
  logic [17:0] e16;
  bit period_mode = 0;
  longint last_done16 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer sum; signed overflow means the signed result is out of range.
  function automatic logic [17:0] ref_add(input int w, input longint a, input longint b,
                                          input longint c);
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint u = a + b + c;
    longint sa = ((a >= half) ? a - full : a) + ((b >= half) ? b - full : b) + c;
    bit ovf = (sa >= half) || (sa < -half);
    return 18'(u + (ovf ? 2 * full : 0));
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (bus8.done) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8_unexpected_done: got done with s=0x%0h, required no done", bus8.s);
      end else begin
        e8 = exp8_q.pop_front();
        check("dut8_result", 64'({bus8.ovf, bus8.cout, bus8.s}), 64'(e8));
        check("dut8_busy_low_at_done", 64'(bus8.busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus16.done) begin
      if (exp16_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut16_unexpected_done: got done with s=0x%0h, required no done", bus16.s);
      end else begin
        e16 = exp16_q.pop_front();
        check("dut16_result", 64'({bus16.ovf, bus16.cout, bus16.s}), 64'(e16));
        check("dut16_busy_low_at_done", 64'(bus16.busy), 64'd0);
      end
      if (period_mode && last_done16 >= 0)
        check("dut16_done_period", 64'(cyc - last_done16), 64'd5);
      last_done16 = cyc;
    end
  end

  // Drivers
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    exp8_q.push_back(ref_add(8, longint'(a), longint'(b), longint'(c)));
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done) seen = 1;
      else if (bus8.busy) busy_cnt++;
    end
    check("dut8_done_seen", 64'(seen), 64'd1);
    check("dut8_busy_cycles", 64'(busy_cnt), 64'd8);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = c;
    exp16_q.push_back(ref_add(16, longint'(a), longint'(b), longint'(c)));
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus16.done) seen = 1;
      else if (bus16.busy) busy_cnt++;
    end
    check("dut16_done_seen", 64'(seen), 64'd1);
    check("dut16_busy_cycles", 64'(busy_cnt), 64'd4);
  endtask

  task automatic wait_done8(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done) seen = 1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at time %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst8_outputs", 64'({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf}), 64'd0);
    check("rst8_state", 64'(bus8.state), 64'(IDLE));
    check("rst16_outputs", 64'({bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf}), 64'd0);
    check("rst16_state", 64'(bus16.state), 64'(IDLE));
    rst_n = 1'b1;

    // Directed 8-bit vectors
    op8(8'h0F, 8'h01, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'h00, 1'b1);
    op8(8'h7F, 8'h01, 1'b0);
    op8(8'h80, 8'h80, 1'b0);

    // start while busy must be dropped
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    exp8_q.push_back(ref_add(8, 64'h12, 64'h34, 0));
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8("dut8_ignore_done_seen");
    repeat (12) @(negedge clk);
    check("dut8_s_held", 64'(bus8.s), 64'h46);
    check("dut8_no_queued_result", 64'(exp8_q.size()), 64'd0);

    // Asynchronous abort mid-run
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h10; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    check("dut8_busy_before_abort", 64'(bus8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort8_outputs", 64'({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf}), 64'd0);
    check("abort8_state", 64'(bus8.state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) saw_done = 1;
    end
    check("abort8_no_done", 64'(saw_done), 64'd0);
    op8(8'h01, 8'h02, 1'b0);

    for (int n = 0; n < 200; n++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // 16-bit: start held high, one result every 5 cycles
    @(negedge clk);
    last_done16 = -1;
    period_mode = 1;
    bus16.start = 1'b1; bus16.a = 16'h8FFF; bus16.b = 16'h7001; bus16.cin = 1'b0;
    for (int k = 0; k < 4; k++) exp16_q.push_back(ref_add(16, 64'h8FFF, 64'h7001, 0));
    repeat (20) @(posedge clk);
    #1;
    bus16.start = 1'b0;
    for (int i = 0; i < 20 && exp16_q.size() != 0; i++) @(negedge clk);
    check("dut16_burst_drained", 64'(exp16_q.size()), 64'd0);
    @(negedge clk);
    period_mode = 0;

    op16(16'hFFFF, 16'h0000, 1'b1);
    op16(16'h7FFF, 16'h0001, 1'b0);
    for (int n = 0; n < 1000; n++)
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    repeat (5) @(negedge clk);
    check("dut8_queue_empty", 64'(exp8_q.size()), 64'd0);
    check("dut16_queue_empty", 64'(exp16_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
